// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared definitions for the data-memory arbiter: default address/data
//   widths and the arbiter FSM state encoding.
package dmem_pkg;

    localparam int DMEM_AW = 8;
    localparam int DMEM_DW = 8;

    // IDLE     : normal arbitration between core and loader
    // LDR_LOCK : loader owns the memory port until it releases ldr_lock
    typedef enum logic {
        IDLE     = 1'b0,
        LDR_LOCK = 1'b1
    } dmem_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port arbiter in front of a single-port data memory. A CPU core and a
//   loader/debug port compete for the memory. Grants are combinational in the
//   cycle a request is accepted. Read data comes back one cycle after the
//   grant and is steered to the port that issued the read. The loader can
//   hold the memory across several accesses with ldr_lock.
//
//   Configuration macro:
//     DMEM_ARB_RR_EN  defined   -> ties in IDLE go to the port that was not
//                                  granted most recently
//                     undefined -> loader has fixed priority on ties
//
//   Ports:
//     clk, reset                     clock, synchronous active-high reset
//     core_req/we/addr/wdata         core request (held until granted)
//     core_gnt/rvalid/rdata          core grant and read return
//     ldr_req/we/lock/addr/wdata     loader request, lock-hold
//     ldr_gnt/rvalid/rdata           loader grant and read return
//     mem_en/we/addr/wdata           memory command port
//     mem_rdata                      memory read data (one cycle latency)
//     busy                           locked, or a read return due next cycle
//     core_stall_cnt                 saturating count of core wait cycles
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,

    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic          ldr_lock,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_rvalid,
    output logic [DW-1:0] ldr_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy,
    output logic [7:0]    core_stall_cnt
);

    dmem_state_t state;

    // Read-return tracker: a read granted this cycle returns next cycle.
    // rd_own_p1 = 1 means the loader issued it.
    logic rd_vld_p1;
    logic rd_own_p1;

`ifdef DMEM_ARB_RR_EN
    // 1 = loader was the most recent grant
    logic last_ldr;
`endif

    // ---- stage p0: grant decision and memory command ----
    always_comb begin
        core_gnt = 1'b0;
        ldr_gnt  = 1'b0;
        if (!reset) begin
            if (state == LDR_LOCK) begin
                ldr_gnt = ldr_req;
            end else if (core_req && ldr_req) begin
`ifdef DMEM_ARB_RR_EN
                core_gnt = last_ldr;
                ldr_gnt  = !last_ldr;
`else
                ldr_gnt  = 1'b1;
`endif
            end else begin
                core_gnt = core_req;
                ldr_gnt  = ldr_req;
            end
        end
    end

    always_comb begin
        mem_en    = core_gnt | ldr_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ldr_gnt) begin
            mem_we    = ldr_we;
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
        end else if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end
    end

    // A read granted now means an rvalid is due next cycle.
    assign busy = !reset && ((state == LDR_LOCK) || (mem_en && !mem_we));

    // ---- stage p1: state, read tracker, stall counter ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rd_vld_p1      <= 1'b0;
            rd_own_p1      <= 1'b0;
            core_stall_cnt <= 8'd0;
`ifdef DMEM_ARB_RR_EN
            last_ldr       <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE:     if (ldr_gnt && ldr_lock) state <= LDR_LOCK;
                LDR_LOCK: if (!ldr_lock)           state <= IDLE;
                default:                           state <= IDLE;
            endcase

            rd_vld_p1 <= mem_en && !mem_we;
            rd_own_p1 <= ldr_gnt;

            if (core_req && !core_gnt && (core_stall_cnt != 8'hFF))
                core_stall_cnt <= core_stall_cnt + 8'd1;

`ifdef DMEM_ARB_RR_EN
            if (mem_en)
                last_ldr <= ldr_gnt;
`endif
        end
    end

    // Read return steering; rdata is forced to zero whenever rvalid is low.
    always_comb begin
        core_rvalid = !reset && rd_vld_p1 && !rd_own_p1;
        ldr_rvalid  = !reset && rd_vld_p1 &&  rd_own_p1;
        core_rdata  = core_rvalid ? mem_rdata : '0;
        ldr_rdata   = ldr_rvalid  ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed scenarios followed by constrained-random traffic, all checked
//   against a behavioural model of the arbiter and a memory image.
//   Honours DMEM_ARB_RR_EN for the tie-break rule.
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          ldr_req, ldr_we, ldr_lock;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic          ldr_gnt, ldr_rvalid;
    logic [DW-1:0] ldr_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;
    logic [7:0]    core_stall_cnt;

    int checks = 0;
    int errors = 0;

    // memory seen by the DUT, and the reference image of it
    logic [DW-1:0] tbmem [256];
    logic [DW-1:0] m_mem [256];

    // reference model state
    bit            m_locked = 1'b0;
    bit            m_last_ldr = 1'b1;
    bit            m_pend = 1'b0;
    bit            m_pend_ldr = 1'b0;
    logic [DW-1:0] m_pend_data = '0;
    int            m_stall = 0;

    // expected access for the current cycle
    bit            eg_c = 1'b0, eg_l = 1'b0, e_rd = 1'b0, e_we = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;

    // memory command observed on the DUT port this cycle
    bit            s_en = 1'b0, s_we = 1'b0;
    logic [AW-1:0] s_addr = '0;
    logic [DW-1:0] s_wdata = '0;

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .core_req       (core_req),
        .core_we        (core_we),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .core_gnt       (core_gnt),
        .core_rvalid    (core_rvalid),
        .core_rdata     (core_rdata),
        .ldr_req        (ldr_req),
        .ldr_we         (ldr_we),
        .ldr_lock       (ldr_lock),
        .ldr_addr       (ldr_addr),
        .ldr_wdata      (ldr_wdata),
        .ldr_gnt        (ldr_gnt),
        .ldr_rvalid     (ldr_rvalid),
        .ldr_rdata      (ldr_rdata),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .busy           (busy),
        .core_stall_cnt (core_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_core(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_req = req; core_we = we; core_addr = a; core_wdata = d;
    endtask

    task automatic set_ldr(input bit req, input bit we, input bit lock, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ldr_req = req; ldr_we = we; ldr_lock = lock; ldr_addr = a; ldr_wdata = d;
    endtask

    // Mid-cycle: predict grants and outputs from the rules, compare.
    task automatic eval();
        bit crv, lrv, e_busy;
        @(negedge clk);
        eg_c = 1'b0;
        eg_l = 1'b0;
        if (!reset) begin
            if (m_locked) begin
                eg_l = ldr_req;                 // locked: core always waits
            end else if (core_req && ldr_req) begin
`ifdef DMEM_ARB_RR_EN
                if (m_last_ldr) eg_c = 1'b1; else eg_l = 1'b1;
`else
                eg_l = 1'b1;
`endif
            end else begin
                eg_c = core_req;
                eg_l = ldr_req;
            end
        end
        e_we    = eg_l ? ldr_we    : (eg_c ? core_we    : 1'b0);
        e_addr  = eg_l ? ldr_addr  : (eg_c ? core_addr  : '0);
        e_wdata = eg_l ? ldr_wdata : (eg_c ? core_wdata : '0);
        e_rd    = (eg_c || eg_l) && !e_we;
        crv     = !reset && m_pend && !m_pend_ldr;
        lrv     = !reset && m_pend &&  m_pend_ldr;
        e_busy  = !reset && (m_locked || e_rd);

        chk("core_gnt",    32'(core_gnt),    32'(eg_c));
        chk("ldr_gnt",     32'(ldr_gnt),     32'(eg_l));
        chk("mem_en",      32'(mem_en),      32'(eg_c || eg_l));
        chk("mem_we",      32'(mem_we),      32'(e_we));
        chk("mem_addr",    32'(mem_addr),    32'(e_addr));
        chk("mem_wdata",   32'(mem_wdata),   32'(e_wdata));
        chk("core_rvalid", 32'(core_rvalid), 32'(crv));
        chk("ldr_rvalid",  32'(ldr_rvalid),  32'(lrv));
        chk("core_rdata",  32'(core_rdata),  crv ? 32'(m_pend_data) : 32'd0);
        chk("ldr_rdata",   32'(ldr_rdata),   lrv ? 32'(m_pend_data) : 32'd0);
        chk("busy",        32'(busy),        32'(e_busy));
        chk("stall_cnt",   32'(core_stall_cnt), 32'(m_stall));

        s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
    endtask

    // Clock edge: memory responds to the DUT command, model advances.
    task automatic advance();
        @(posedge clk);
        #1;
        if (s_en && s_we) tbmem[s_addr] = s_wdata;
        mem_rdata = (s_en && !s_we) ? tbmem[s_addr] : DW'($urandom);
        if (reset) begin
            m_locked = 1'b0; m_pend = 1'b0; m_pend_ldr = 1'b0;
            m_stall = 0; m_last_ldr = 1'b1;
        end else begin
            if (m_locked) m_locked = ldr_lock;
            else if (eg_l && ldr_lock) m_locked = 1'b1;
            m_pend     = e_rd;
            m_pend_ldr = eg_l;
            if (e_rd) m_pend_data = m_mem[e_addr];
            if (eg_c || eg_l) begin
                if (e_we) m_mem[e_addr] = e_wdata;
                m_last_ldr = eg_l;
            end
            if (core_req && !eg_c && m_stall < 255) m_stall++;
        end
    endtask

    task automatic cyc();
        eval();
        advance();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tbmem[i] = DW'($urandom);
            m_mem[i] = tbmem[i];
        end
        tbmem[2] = 8'h01;
        m_mem[2] = 8'h01;
        mem_rdata = '0;

        // reset with both ports requesting: nothing may leak out
        reset = 1'b1;
        set_core(1'b1, 1'b0, 8'h05, 8'h00);
        set_ldr(1'b1, 1'b0, 1'b1, 8'h07, 8'h00);
        advance();
        eval();
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_stall",  32'(core_stall_cnt), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        advance();
        reset = 1'b0;

        // core read of addr 2 returns 8'h01 one cycle later
        set_ldr(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_core(1'b1, 1'b0, 8'h02, 8'h00);
        eval(); chk("rd_core_gnt", 32'(core_gnt), 32'd1); advance();
        set_core(1'b0, 1'b0, 8'h00, 8'h00);
        eval();
        chk("rd_core_rvalid", 32'(core_rvalid), 32'd1);
        chk("rd_core_rdata",  32'(core_rdata),  32'h01);
        chk("rd_ldr_rvalid",  32'(ldr_rvalid),  32'd0);
        advance();

`ifndef DMEM_ARB_RR_EN
        // tie in IDLE: loader wins, core follows
        reset = 1'b1; cyc(); reset = 1'b0;
        set_core(1'b1, 1'b0, 8'h03, 8'h00);
        set_ldr(1'b1, 1'b0, 1'b0, 8'h04, 8'h00);
        eval();
        chk("tie_ldr_gnt",  32'(ldr_gnt),  32'd1);
        chk("tie_core_gnt", 32'(core_gnt), 32'd0);
        advance();
        set_ldr(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        eval();
        chk("tie_core_next", 32'(core_gnt), 32'd1);
        chk("tie_stall",     32'(core_stall_cnt), 32'd1);
        advance();
        set_core(1'b0, 1'b0, 8'h00, 8'h00);
        cyc();

        // locked loader burst of four writes; lock released on the fourth
        reset = 1'b1; cyc(); reset = 1'b0;
        set_core(1'b1, 1'b1, 8'h10, 8'hAA);
        for (int k = 1; k <= 4; k++) begin
            set_ldr(1'b1, 1'b1, k < 4, AW'(k), DW'(8'h50 + k));
            eval();
            chk("burst_ldr_gnt",  32'(ldr_gnt),  32'd1);
            chk("burst_core_gnt", 32'(core_gnt), 32'd0);
            advance();
        end
        set_ldr(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        eval();
        chk("burst_core_after", 32'(core_gnt), 32'd1);
        chk("burst_stall",      32'(core_stall_cnt), 32'd4);
        advance();
        set_core(1'b0, 1'b0, 8'h00, 8'h00);
        cyc();
`else
        // round-robin ties after reset: core, loader, core, loader
        reset = 1'b1; cyc(); reset = 1'b0;
        set_core(1'b1, 1'b0, 8'h01, 8'h00);
        set_ldr(1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
        for (int k = 0; k < 4; k++) begin
            eval();
            chk("rr_core_gnt", 32'(core_gnt), 32'((k % 2) == 0));
            chk("rr_ldr_gnt",  32'(ldr_gnt),  32'((k % 2) == 1));
            advance();
        end
        set_core(1'b0, 1'b0, 8'h00, 8'h00);
        set_ldr(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc();
`endif

        // long lock: stall counter saturates at 255
        reset = 1'b1; cyc(); reset = 1'b0;
        set_core(1'b1, 1'b0, 8'h01, 8'h00);
        set_ldr(1'b1, 1'b1, 1'b1, 8'h09, 8'h33);
        repeat (300) cyc();
        eval(); chk("sat_stall", 32'(core_stall_cnt), 32'd255); advance();
        set_ldr(1'b1, 1'b1, 1'b0, 8'h09, 8'h33);
        cyc();
        set_ldr(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc();
        set_core(1'b0, 1'b0, 8'h00, 8'h00);

        // reset while locked with a loader read in flight
        reset = 1'b1; cyc(); reset = 1'b0;
        set_ldr(1'b1, 1'b0, 1'b1, 8'h20, 8'h00);
        cyc();
        cyc();
        reset = 1'b1;
        set_ldr(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        eval(); chk("rstlk_rvalid_in_rst", 32'(ldr_rvalid), 32'd0); advance();
        reset = 1'b0;
        set_core(1'b1, 1'b1, 8'h30, 8'h77);
        eval();
        chk("rstlk_core_gnt", 32'(core_gnt),   32'd1);
        chk("rstlk_rvalid",   32'(ldr_rvalid), 32'd0);
        chk("rstlk_busy",     32'(busy),       32'd0);
        advance();
        set_core(1'b0, 1'b0, 8'h00, 8'h00);
        set_ldr(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc();

        // random traffic; requesters hold their request until granted
        reset = 1'b1; cyc(); reset = 1'b0;
        repeat (3000) begin
            if (!core_req || eg_c)
                set_core($urandom_range(0, 2) != 0, 1'($urandom),
                         AW'($urandom_range(0, 15)), DW'($urandom));
            if (!ldr_req || eg_l)
                set_ldr($urandom_range(0, 2) != 0, 1'($urandom), 1'b0,
                        AW'($urandom_range(0, 15)), DW'($urandom));
            ldr_lock = ($urandom_range(0, 2) == 0);
            reset    = ($urandom_range(0, 99) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 8, data memory address width.
REQ-002 The block SHALL have parameter DW, default 8, data memory data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 core_req, core_we  input  1 each  CPU core access request, write enable.
REQ-006 core_addr  input  AW; core_wdata  input  DW  core access address, write data.
REQ-007 core_gnt, core_rvalid  output  1 each; core_rdata  output  DW  core grant, read-return valid, read data.
REQ-008 ldr_req, ldr_we, ldr_lock  input  1 each  loader/debug request, write enable, lock-hold.
REQ-009 ldr_addr  input  AW; ldr_wdata  input  DW  loader access address, write data.
REQ-010 ldr_gnt, ldr_rvalid  output  1 each; ldr_rdata  output  DW  loader grant, read valid, read data.
REQ-011 mem_en, mem_we  output  1 each; mem_addr  output  AW; mem_wdata  output  DW  data memory port.
REQ-012 mem_rdata  input  DW  data memory read data, valid one cycle after mem_en with mem_we=0.
REQ-013 busy  output  1  state not IDLE or read return pending.
REQ-014 core_stall_cnt  output  8  cycles core_req high without core_gnt.

Function
REQ-015 At most one of core_gnt/ldr_gnt SHALL be high per cycle; grant is combinational in the cycle the request is accepted.
REQ-016 mem_en SHALL equal core_gnt|ldr_gnt; mem_we/addr/wdata SHALL come from the granted port; all zero when no grant.
REQ-017 A requester SHALL hold req/we/addr/wdata stable until granted; the arbiter SHALL NOT depend on request withdrawal.
REQ-018 A granted read SHALL assert that port's rvalid exactly one cycle later with rdata=mem_rdata; writes SHALL produce no rvalid; rdata SHALL be zero when rvalid low.
REQ-019 FSM states: IDLE, LDR_LOCK; reset state IDLE.
REQ-020 IDLE, single requester: that requester SHALL be granted.
REQ-021 IDLE, both requesting: loader SHALL win (fixed priority) unless DMEM_ARB_RR_EN is defined.
REQ-022 A granted loader access with ldr_lock=1 SHALL move IDLE->LDR_LOCK next cycle.
REQ-023 LDR_LOCK: core SHALL never be granted; ldr_req SHALL be granted every cycle it is high.
REQ-024 LDR_LOCK->IDLE on the first cycle ldr_lock is sampled low, whether or not ldr_req is high; that cycle's ldr_req is still granted.
REQ-025 core_stall_cnt SHALL increment when core_req=1 and core_gnt=0, saturate at 255, never clear except on reset.
REQ-026 busy SHALL be high when state is LDR_LOCK or any rvalid is due next cycle.

Reset
REQ-027 reset SHALL force state IDLE, all gnt/rvalid/mem_en/mem_we low, rdata/addr/wdata zero, core_stall_cnt 0, busy 0.
REQ-028 reset asserted with a read in flight SHALL drop that rvalid; reset during LDR_LOCK SHALL return to IDLE.
REQ-029 Under DMEM_ARB_RR_EN, reset SHALL set last-granted to loader so the core wins the first tie.

Configuration
REQ-030 Macro DMEM_ARB_RR_EN defined: IDLE ties SHALL go to the port not granted most recently (1-bit last-granted register, updated on every grant including LDR_LOCK).
REQ-031 Macro DMEM_ARB_RR_EN undefined: loader fixed priority; no last-granted register.

Structure
REQ-032 Package dmem_pkg SHALL hold AW/DW defaults and the FSM state enum (IDLE, LDR_LOCK).
REQ-033 Single module; no sub-module; the read-return tracker is a 2-bit register (valid, owner) inside dmem_arbiter.

Verification
REQ-034 Core read addr 8'h02, mem returns 8'h01 -> core_gnt same cycle, core_rvalid=1 with core_rdata=8'h01 next cycle, ldr_rvalid=0.
REQ-035 Both request in IDLE, fixed priority -> ldr_gnt=1, core_gnt=0, core_stall_cnt=1; next cycle core granted.
REQ-036 Loader writes addr 1..4 with ldr_lock=1 while core_req held -> 4 consecutive ldr_gnt, core_stall_cnt=4, core granted the cycle after ldr_lock drops.
REQ-037 Core held ungranted 300 cycles under lock -> core_stall_cnt=255.
REQ-038 reset asserted in LDR_LOCK with loader read in flight -> next cycle IDLE, ldr_rvalid=0, busy=0.
REQ-039 DMEM_ARB_RR_EN, both requesting 4 cycles after reset -> grants core, ldr, core, ldr.
